// File: rtl/ms_rd_slave.sv
// Register-file responder with split address/data write phases, single-cycle
// registered reads, same-edge write-to-read bypass and a stall window after address-3 accesses.
module ms_rd_slave #(
   parameter int REG3_WAIT = 1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       wr_en,
   input  logic [1:0] addr,
   input  logic [7:0] data,
   input  logic       rd_req,
   input  logic [1:0] rd_addr,
   output logic       sready,
   output logic [7:0] rd_data,
   output logic       rd_valid
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] LP_WAIT     = 4'(REG3_WAIT);
   localparam logic [3:0] LP_WAIT_M1  = LP_WAIT - 4'd1;
   localparam logic       LP_STALL_EN = (REG3_WAIT > 0);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_wr_pend;
   logic [1:0] r_wr_addr;
   logic [7:0] r_r0;
   logic [7:0] r_r1;
   logic       r_r2;
   logic [3:0] r_r3;
   logic [7:0] r_rd_data;
   logic       r_rd_valid;

   logic       w_sready;
   logic       w_wr_acc;
   logic       w_rd_acc;
   logic       w_hit3;
   logic       w_bypass;
   logic [7:0] w_reg_val;
   logic [7:0] w_wr_val;
   logic [7:0] w_rd_next;

   assign w_sready = (r_state == ST_IDLE);
   assign w_wr_acc = wr_en  & w_sready;
   assign w_rd_acc = rd_req & w_sready;
   assign w_hit3   = (w_wr_acc && (addr == 2'd3)) || (w_rd_acc && (rd_addr == 2'd3));
   assign w_bypass = r_wr_pend && (r_wr_addr == rd_addr);

   // Read-side view of the register file and of the in-flight write data.
   always_comb begin
      w_reg_val = 8'h00;
      w_wr_val  = 8'h00;
      case (rd_addr)
         2'd0:    w_reg_val = r_r0;
         2'd1:    w_reg_val = r_r1;
         2'd2:    w_reg_val = {7'b0000000, r_r2};
         2'd3:    w_reg_val = {4'b0000, r_r3};
         default: w_reg_val = 8'h00;
      endcase
      case (r_wr_addr)
         2'd0, 2'd1: w_wr_val = data;
         2'd2:       w_wr_val = {7'b0000000, data[0]};
         2'd3:       w_wr_val = {4'b0000, data[3:0]};
         default:    w_wr_val = 8'h00;
      endcase
      if (w_bypass) begin
         w_rd_next = w_wr_val;
      end else begin
         w_rd_next = w_reg_val;
      end
   end

   // Write pipeline: capture address on acceptance, commit data one edge later.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_pend <= 1'b0;
         r_wr_addr <= 2'd0;
         r_r0      <= 8'h00;
         r_r1      <= 8'h00;
         r_r2      <= 1'b0;
         r_r3      <= 4'h0;
      end else begin
         r_wr_pend <= w_wr_acc;
         r_wr_addr <= w_wr_acc ? addr : r_wr_addr;
         if (r_wr_pend) begin
            case (r_wr_addr)
               2'd0:    r_r0 <= data;
               2'd1:    r_r1 <= data;
               2'd2:    r_r2 <= data[0];
               2'd3:    r_r3 <= data[3:0];
               default: r_r0 <= r_r0;
            endcase
         end
      end
   end

   // Read response: one-cycle valid strobe, data held between reads.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_data  <= 8'h00;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_data <= w_rd_next;
         end
      end
   end

   // Stall FSM: address-3 access opens a REG3_WAIT-cycle not-ready window.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit3 && LP_STALL_EN) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= LP_WAIT_M1;
               end
            end
            ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

   assign sready   = w_sready;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_ms_rd_slave.sv
// Directed bench for ms_rd_slave: three instances (REG3_WAIT = 1, 3, 0) share one stimulus bus.
module tb_ms_rd_slave;

   logic       clk;
   logic       rstn;
   logic       wr_en;
   logic [1:0] addr;
   logic [7:0] data;
   logic       rd_req;
   logic [1:0] rd_addr;

   logic       sready1, sready3, sready0;
   logic [7:0] rd_data1, rd_data3, rd_data0;
   logic       rd_valid1, rd_valid3, rd_valid0;

   int n_checks;
   int n_errors;

   ms_rd_slave #(.REG3_WAIT(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .addr(addr), .data(data),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .sready(sready1), .rd_data(rd_data1), .rd_valid(rd_valid1)
   );

   ms_rd_slave #(.REG3_WAIT(3)) u_dut3 (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .addr(addr), .data(data),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .sready(sready3), .rd_data(rd_data3), .rd_valid(rd_valid3)
   );

   ms_rd_slave #(.REG3_WAIT(0)) u_dut0 (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .addr(addr), .data(data),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .sready(sready0), .rd_data(rd_data0), .rd_valid(rd_valid0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      wr_en = 1'b0; rd_req = 1'b0; addr = 2'd0; rd_addr = 2'd0; data = 8'h00;
      tick();
      rstn = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rstn = 1'b0;
      wr_en = 1'b0; rd_req = 1'b0; addr = 2'd0; rd_addr = 2'd0; data = 8'h00;
      #2;
      check("rst_sready", {7'd0, sready1}, 8'h01);
      check("rst_valid", {7'd0, rd_valid1}, 8'h00);
      check("rst_data", rd_data1, 8'h00);
      tick();
      rstn = 1'b1;

      // Back-to-back writes 0..3 on REG3_WAIT=1
      wr_en = 1'b1; addr = 2'd0;
      tick();
      addr = 2'd1; data = 8'h00;
      tick();
      addr = 2'd2; data = 8'h04;
      tick();
      addr = 2'd3; data = 8'h08;
      tick();
      check("b2b_stall", {7'd0, sready1}, 8'h00);
      wr_en = 1'b0; data = 8'h0C;
      tick();
      check("b2b_ready", {7'd0, sready1}, 8'h01);
      rd_req = 1'b1; rd_addr = 2'd0;
      tick();
      check("b2b_r0_valid", {7'd0, rd_valid1}, 8'h01);
      check("b2b_r0", rd_data1, 8'h00);
      rd_addr = 2'd1;
      tick();
      check("b2b_r1", rd_data1, 8'h04);
      rd_addr = 2'd2;
      tick();
      check("b2b_r2", rd_data1, 8'h00);
      rd_addr = 2'd3;
      tick();
      check("b2b_r3", rd_data1, 8'h0C);
      check("rd3_stall", {7'd0, sready1}, 8'h00);
      rd_req = 1'b0;
      tick();
      check("rd3_valid_low", {7'd0, rd_valid1}, 8'h00);
      check("rd3_hold", rd_data1, 8'h0C);
      check("rd3_ready", {7'd0, sready1}, 8'h01);

      // Write R1=A5 and R2 from 0xFF, then read back
      wr_en = 1'b1; addr = 2'd1;
      tick();
      addr = 2'd2; data = 8'hA5;
      tick();
      wr_en = 1'b0; data = 8'hFF;
      tick();
      data = 8'h00;
      rd_req = 1'b1; rd_addr = 2'd1;
      tick();
      check("a5_valid", {7'd0, rd_valid1}, 8'h01);
      check("a5_data", rd_data1, 8'hA5);
      rd_req = 1'b0;
      tick();
      check("a5_valid_low", {7'd0, rd_valid1}, 8'h00);
      check("a5_hold", rd_data1, 8'hA5);
      rd_req = 1'b1; rd_addr = 2'd2;
      tick();
      check("r2_zext", rd_data1, 8'h01);
      rd_req = 1'b0;
      tick();

      // Bypass: read addr 0 at the data-phase edge of a write to addr 0
      wr_en = 1'b1; addr = 2'd0;
      tick();
      wr_en = 1'b0; data = 8'h3C; rd_req = 1'b1; rd_addr = 2'd0;
      tick();
      check("byp_valid", {7'd0, rd_valid1}, 8'h01);
      check("byp_data", rd_data1, 8'h3C);
      rd_req = 1'b0; data = 8'h00;
      tick();

      // REG3_WAIT=3: stall window ignores requests
      do_reset();
      wr_en = 1'b1; addr = 2'd0;
      tick();
      wr_en = 1'b0; data = 8'h11;
      tick();
      rd_req = 1'b1; rd_addr = 2'd3;
      tick();
      check("w3_rd_valid", {7'd0, rd_valid3}, 8'h01);
      check("w3_rd_data", rd_data3, 8'h00);
      check("w3_stall1", {7'd0, sready3}, 8'h00);
      rd_req = 1'b1; rd_addr = 2'd0; wr_en = 1'b1; addr = 2'd0; data = 8'h77;
      tick();
      check("w3_stall2", {7'd0, sready3}, 8'h00);
      check("w3_ign_valid2", {7'd0, rd_valid3}, 8'h00);
      tick();
      check("w3_stall3", {7'd0, sready3}, 8'h00);
      check("w3_ign_valid3", {7'd0, rd_valid3}, 8'h00);
      wr_en = 1'b0; rd_req = 1'b0;
      tick();
      check("w3_ready4", {7'd0, sready3}, 8'h01);
      check("w3_ign_valid4", {7'd0, rd_valid3}, 8'h00);
      rd_req = 1'b1; rd_addr = 2'd0;
      tick();
      check("w3_r0_unchanged", rd_data3, 8'h11);
      rd_req = 1'b0;
      tick();

      // Reset between address and data phase discards the write
      do_reset();
      wr_en = 1'b1; addr = 2'd3;
      tick();
      wr_en = 1'b0; data = 8'h0F;
      tick();
      tick();
      rd_req = 1'b1; rd_addr = 2'd3;
      tick();
      check("rst_pre_r3", rd_data1, 8'h0F);
      rd_req = 1'b0;
      tick();
      wr_en = 1'b1; addr = 2'd0; data = 8'h00;
      tick();
      wr_en = 1'b0; data = 8'h99;
      rstn = 1'b0;
      #1;
      check("arst_data", rd_data1, 8'h00);
      check("arst_valid", {7'd0, rd_valid1}, 8'h00);
      check("arst_sready", {7'd0, sready1}, 8'h01);
      tick();
      rstn = 1'b1;
      rd_req = 1'b1; rd_addr = 2'd0;
      tick();
      check("arst_r0", rd_data1, 8'h00);
      check("arst_first_acc", {7'd0, rd_valid1}, 8'h01);
      rd_addr = 2'd3;
      tick();
      check("arst_r3", rd_data1, 8'h00);
      rd_req = 1'b0;
      tick();

      // REG3_WAIT=0: continuous addr-3 writes, each observed by bypass read
      do_reset();
      wr_en = 1'b1; addr = 2'd3; rd_req = 1'b1; rd_addr = 2'd3;
      tick();
      for (int i = 1; i <= 6; i++) begin
         data = 8'(i);
         tick();
         check("w0_sready", {7'd0, sready0}, 8'h01);
         check("w0_byp", rd_data0, 8'(i));
      end
      wr_en = 1'b0; rd_req = 1'b0; data = 8'h0A;
      tick();
      rd_req = 1'b1;
      tick();
      check("w0_last", rd_data0, 8'h0A);
      check("w0_sready_end", {7'd0, sready0}, 8'h01);
      rd_req = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ms_rd_slave.md
MS_RD_SLAVE -- requirements
Module: ms_rd_slave

Interface
REQ-001 SHALL have parameter REG3_WAIT, default 1: number of stall cycles after any accepted access to address 3; legal range 0..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port wr_en  input  1  write address-phase qualifier.
REQ-005 SHALL have port addr  input  2  write address, address phase.
REQ-006 SHALL have port data  input  8  write data, data phase, one cycle after address phase.
REQ-007 SHALL have port rd_req  input  1  read request qualifier.
REQ-008 SHALL have port rd_addr  input  2  read address.
REQ-009 SHALL have port sready  output  1  responder ready; an access is accepted only in a cycle with sready=1.
REQ-010 SHALL have port rd_data  output  8  read data, registered.
REQ-011 SHALL have port rd_valid  output  1  rd_data valid strobe, registered.

Function
REQ-012 SHALL hold four registers: R0 8-bit, R1 8-bit, R2 1-bit (data[0]), R3 4-bit (data[3:0]).
REQ-013 SHALL accept a write when wr_en=1 and sready=1 at a rising edge; addr is captured at that edge (cycle N).
REQ-014 SHALL sample data at the next rising edge (end of cycle N+1) and update the addressed register at that same edge, regardless of sready in cycle N+1.
REQ-015 SHALL support back-to-back writes: address phase of write k+1 overlaps data phase of write k.
REQ-016 SHALL accept a read when rd_req=1 and sready=1 at a rising edge (cycle N); rd_data SHALL be valid, with rd_valid=1, during cycle N+1 only.
REQ-017 SHALL zero-extend R2 and R3 to 8 bits on rd_data.
REQ-018 SHALL bypass: a read accepted at the same edge that completes a write data phase to the same address SHALL return the newly written value.
REQ-019 SHALL accept a read and a write address phase at the same edge independently; both count toward the address-3 stall rule.
REQ-020 SHALL hold rd_data at its last value when rd_valid=0.
REQ-021 SHALL implement a two-state machine: IDLE (sready=1) and WAIT (sready=0); sready SHALL be decoded from registered state only.
REQ-022 IDLE->WAIT when an access (write or read) to address 3 is accepted and REG3_WAIT>0; a 4-bit counter loads REG3_WAIT-1.
REQ-023 WAIT: counter decrements each cycle; WAIT->IDLE at the edge where counter=0; sready is therefore 0 for exactly REG3_WAIT cycles (N+1..N+REG3_WAIT).
REQ-024 With REG3_WAIT=0 SHALL remain in IDLE permanently.
REQ-025 In WAIT, wr_en and rd_req SHALL be ignored (no capture, no rd_valid); a data phase pending from the access that entered WAIT SHALL still complete.
REQ-026 Unaccepted requests SHALL NOT be queued; the initiator re-presents them.

Reset
REQ-027 On rstn=0, asynchronously: R0..R3=0, rd_data=0, rd_valid=0, state=IDLE (sready=1), counter=0, pending write data phase cleared.
REQ-028 Reset asserted between address and data phase SHALL discard that write; registers stay 0.
REQ-029 First access SHALL be accepted at the first rising edge with rstn=1.

Verification
REQ-030 Writes addr 0,1,2,3 back-to-back, data 0x00,0x04,0x08,0x0C -> R0=0x00, R1=0x04, R2=0, R3=0xC; sready low one cycle after addr-3 edge (REG3_WAIT=1).
REQ-031 Write R1=0xA5, then read addr 1 two cycles later -> rd_valid=1 one cycle after the read edge, rd_data=0xA5; rd_valid low next cycle, rd_data held.
REQ-032 Write addr 0 data 0x3C with read addr 0 issued at the data-phase edge -> rd_data=0x3C (bypass).
REQ-033 REG3_WAIT=3, read addr 3 -> sready=0 for 3 cycles; wr_en pulses during them ignored (registers unchanged, no rd_valid); sready=1 on 4th cycle.
REQ-034 Write R3=0x0F, then addr-0 address phase, rstn=0 before data phase -> all registers 0, rd_valid=0, sready=1 after release; read addr 3 returns 0x00.
REQ-035 REG3_WAIT=0, continuous writes to addr 3 -> sready never deasserts, every write lands.
